// File: rtl/aes_pkg.sv
// Shared AES types, constants and byte-level helpers (S-box, rcon, xtime).
package aes_pkg;

  typedef logic [127:0] aes_block_t;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL,
    DONE
  } aes_seq_state_e;

  localparam int AES128_ROUNDS = 10;

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] aes_sbox(input logic [7:0] b);
    logic [10:0] bitIdx;
    bitIdx = {~b, 3'b000};
    return SBOX_TABLE[bitIdx +: 8];
  endfunction

  function automatic logic [7:0] aes_rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/add_round_key.sv
// AES AddRoundKey.
module add_round_key (
  input  logic [127:0] stateIn,
  input  logic [127:0] roundKey,
  output logic [127:0] stateOut
);

  assign stateOut = stateIn ^ roundKey;

endmodule

// File: rtl/aes_key_expand_step.sv
// One AES-128 key-schedule step: previous round key + rcon -> next round key.
module aes_key_expand_step (
  input  logic [127:0] prevKey,
  input  logic [7:0]   rcon,
  output logic [127:0] nextKey
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rotW, subW, temp;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = prevKey;
  assign rotW = {w3[23:0], w3[31:24]};

  sub_bytes #(.NumBytes(4)) uSubWord (.dataIn(rotW), .dataOut(subW));

  assign temp = subW ^ {rcon, 24'h000000};
  assign n0   = w0 ^ temp;
  assign n1   = w1 ^ n0;
  assign n2   = w2 ^ n1;
  assign n3   = w3 ^ n2;
  assign nextKey = {n0, n1, n2, n3};

endmodule

// File: rtl/encryption_rounds.sv
// One full AES middle round: SubBytes, ShiftRows, MixColumns, AddRoundKey.
module encryption_rounds
  import aes_pkg::*;
(
  input  aes_block_t stateIn,
  input  aes_block_t roundKey,
  output aes_block_t stateOut
);

  aes_block_t subOut;
  aes_block_t shiftOut;
  aes_block_t mixOut;

  sub_bytes #(.NumBytes(16)) uSub (.dataIn(stateIn), .dataOut(subOut));
  shift_rows uShift (.dataIn(subOut), .dataOut(shiftOut));

  for (genvar c = 0; c < 4; c++) begin : gMix
    logic [7:0] a0, a1, a2, a3;
    assign a0 = shiftOut[8*(15-4*c) +: 8];
    assign a1 = shiftOut[8*(14-4*c) +: 8];
    assign a2 = shiftOut[8*(13-4*c) +: 8];
    assign a3 = shiftOut[8*(12-4*c) +: 8];
    assign mixOut[8*(15-4*c) +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign mixOut[8*(14-4*c) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign mixOut[8*(13-4*c) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign mixOut[8*(12-4*c) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

  add_round_key uArk (.stateIn(mixOut), .roundKey(roundKey), .stateOut(stateOut));

endmodule

// File: rtl/shift_rows.sv
// AES ShiftRows; byte i sits at [127-8i -: 8], column-major (i = 4*col + row).
module shift_rows (
  input  logic [127:0] dataIn,
  output logic [127:0] dataOut
);

  for (genvar c = 0; c < 4; c++) begin : gCol
    for (genvar r = 0; r < 4; r++) begin : gRow
      localparam int Dst = 15 - (4*c + r);
      localparam int Src = 15 - (4*((c + r) % 4) + r);
      assign dataOut[8*Dst +: 8] = dataIn[8*Src +: 8];
    end
  end

endmodule

// File: rtl/sub_bytes.sv
// Byte-wise S-box substitution over NumBytes bytes.
module sub_bytes
  import aes_pkg::*;
#(
  parameter int NumBytes = 16
) (
  input  logic [8*NumBytes-1:0] dataIn,
  output logic [8*NumBytes-1:0] dataOut
);

  for (genvar i = 0; i < NumBytes; i++) begin : gByte
    assign dataOut[8*i +: 8] = aes_sbox(dataIn[8*i +: 8]);
  end

endmodule

// File: rtl/aes_encrypt_sequencer.sv
// Iterative AES-128 encryption sequencer, one round per clock, keys expanded on the fly.
// Optional block counter output enabled by AES_SEQ_PERF_CNT_EN.
//
// state | meaning
// IDLE  | ready_o=1, waiting for v_i
// ROUND | applying middle rounds 1..num_rounds_p-1
// FINAL | applying the last round (no MixColumns)
// DONE  | ciphertext presented with v_o=1 until yumi_i
module aes_encrypt_sequencer
  import aes_pkg::*;
#(
  parameter int num_rounds_p = AES128_ROUNDS
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         v_i,
  output logic         ready_o,
  input  logic [127:0] plaintext_i,
  input  logic [127:0] key_i,
  output logic         v_o,
  output logic [127:0] ciphertext_o,
  input  logic         yumi_i,
  output logic [3:0]   round_o
`ifdef AES_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]  blocks_done_o
`endif
);

  localparam int RndW = $clog2(num_rounds_p + 1);

  aes_seq_state_e  stateQ, stateD;
  aes_block_t      blockQ, keyQ;
  aes_block_t      nextKey, roundOut, finalSub, finalShift, finalOut;
  logic [RndW-1:0] rndQ;
  logic [7:0]      rcon;

  // rndQ already reads num_rounds_p while in FINAL, so one rcon lookup serves both.
  assign rcon = aes_rcon(4'(rndQ));

  aes_key_expand_step uKeyStep (.prevKey(keyQ), .rcon(rcon), .nextKey(nextKey));

  encryption_rounds uRound (.stateIn(blockQ), .roundKey(nextKey), .stateOut(roundOut));

  sub_bytes #(.NumBytes(16)) uFinalSub (.dataIn(blockQ), .dataOut(finalSub));
  shift_rows uFinalShift (.dataIn(finalSub), .dataOut(finalShift));
  add_round_key uFinalArk (.stateIn(finalShift), .roundKey(nextKey), .stateOut(finalOut));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) stateQ <= IDLE;
    else         stateQ <= stateD;
  end

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE:    if (v_i) stateD = ROUND;
      ROUND:   if (rndQ == RndW'(num_rounds_p - 1)) stateD = FINAL;
      FINAL:   stateD = DONE;
      DONE:    if (yumi_i) stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  always_comb begin
    ready_o      = 1'b0;
    v_o          = 1'b0;
    round_o      = 4'd0;
    ciphertext_o = '0;
    case (stateQ)
      IDLE:    ready_o = 1'b1;
      ROUND:   round_o = 4'(rndQ);
      FINAL:   round_o = 4'(num_rounds_p);
      DONE: begin
        v_o          = 1'b1;
        ciphertext_o = blockQ;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      blockQ <= '0;
      keyQ   <= '0;
      rndQ   <= '0;
    end else begin
      case (stateQ)
        IDLE: if (v_i) begin
          blockQ <= plaintext_i ^ key_i;
          keyQ   <= key_i;
          rndQ   <= RndW'(1);
        end
        ROUND: begin
          blockQ <= roundOut;
          keyQ   <= nextKey;
          rndQ   <= rndQ + RndW'(1);
        end
        FINAL: begin
          blockQ <= finalOut;
          keyQ   <= nextKey;
          rndQ   <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef AES_SEQ_PERF_CNT_EN
  logic [31:0] blocksDoneQ;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) blocksDoneQ <= '0;
    else if (stateQ == DONE && yumi_i && blocksDoneQ != 32'hFFFF_FFFF)
      blocksDoneQ <= blocksDoneQ + 32'd1;
  end

  assign blocks_done_o = blocksDoneQ;
`endif

  // The consumer may only take a result that is actually being presented.
  yumiOnlyWithValid: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);

endmodule

// File: tb/tb_aes_encrypt_sequencer.sv
// Self-checking bench: known-answer table, randomized blocks vs a byte-level AES model,
// backpressure, reset-abort and (with AES_SEQ_PERF_CNT_EN) block counter cases.
module tb_aes_encrypt_sequencer;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic         v_i;
  logic         ready_o;
  logic [127:0] plaintext_i;
  logic [127:0] key_i;
  logic         v_o;
  logic [127:0] ciphertext_o;
  logic         yumi_i;
  logic [3:0]   round_o;
`ifdef AES_SEQ_PERF_CNT_EN
  logic [31:0]  blocks_done_o;
`endif

  aes_encrypt_sequencer dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .v_i(v_i),
    .ready_o(ready_o),
    .plaintext_i(plaintext_i),
    .key_i(key_i),
    .v_o(v_o),
    .ciphertext_o(ciphertext_o),
    .yumi_i(yumi_i),
    .round_o(round_o)
`ifdef AES_SEQ_PERF_CNT_EN
    ,
    .blocks_done_o(blocks_done_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int consumed = 0;
  int roundLog[$];
  logic [7:0] sboxTab[256];

  typedef struct {
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] ct;
  } vec_t;
  vec_t vecs[3];

  localparam logic [127:0] APPB_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] APPB_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] APPB_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] APPC_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] APPC_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] APPC_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  // ---------------- reference model (GF(2^8) arithmetic, byte arrays) ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic buildSbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sboxTab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] refEncrypt(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0]  s[16];
    logic [7:0]  t[16];
    logic [31:0] w[44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    logic [7:0]  a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = 32'(key >> (32*(3-i)));
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sboxTab[tmp[31:24]], sboxTab[tmp[23:16]], sboxTab[tmp[15:8]], sboxTab[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h000000};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = 8'(pt >> (8*(15-i))) ^ 8'(key >> (8*(15-i)));
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sboxTab[s[i]];
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++) t[4*c+j] = s[4*((c+j)%4)+j];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < 10) begin
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
        for (int j = 0; j < 4; j++) s[4*c+j] = s[4*c+j] ^ 8'(w[4*r+c] >> (8*(3-j)));
      end
    end
    res = '0;
    for (int i = 0; i < 16; i++) res = {res[119:0], s[i]};
    return res;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Called just after a negedge with the DUT idle; returns at the negedge where v_o is seen.
  task automatic runBlock(input logic [127:0] pt, input logic [127:0] key, input bit noise,
                          output logic [127:0] ct, output int lat);
    int n;
    check("ready_o before accept", ready_o, 1);
    plaintext_i = pt;
    key_i       = key;
    v_i         = 1'b1;
    @(negedge clk_i);
    v_i = 1'b0;
    n = 0;
    roundLog.delete();
    roundLog.push_back(int'(round_o));
    while (!v_o && n < 40) begin
      @(negedge clk_i);
      n++;
      roundLog.push_back(int'(round_o));
      if (noise) begin
        v_i         = 1'($urandom_range(0, 1));
        plaintext_i = rand128();
        key_i       = rand128();
      end
    end
    v_i = 1'b0;
    if (!v_o) check("v_o timeout", v_o, 1);
    ct  = ciphertext_o;
    lat = n;
  endtask

  task automatic consume(input int delay);
    repeat (delay) @(negedge clk_i);
    yumi_i = 1'b1;
    @(negedge clk_i);
    yumi_i = 1'b0;
    consumed++;
    check("ready_o after yumi", ready_o, 1);
    check("v_o after yumi", v_o, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [127:0] ct;
    logic [127:0] pt;
    logic [127:0] key;
    int lat;
    int n;
    int roundErrs;

    reset_i = 1'b1; v_i = 1'b0; yumi_i = 1'b0; plaintext_i = '0; key_i = '0;
    buildSbox();
    vecs[0] = '{pt: APPB_PT, key: APPB_KEY, ct: APPB_CT};
    vecs[1] = '{pt: APPC_PT, key: APPC_KEY, ct: APPC_CT};
    vecs[2] = '{pt: 128'h0, key: 128'h0, ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    repeat (2) @(negedge clk_i);
    check("reset ready_o", ready_o, 1);
    check("reset v_o", v_o, 0);
    check("reset ciphertext_o", ciphertext_o, 0);
    check("reset round_o", round_o, 0);
    reset_i = 1'b0;
    @(negedge clk_i);

    // Known-answer table
    for (int i = 0; i < 3; i++) begin
      runBlock(vecs[i].pt, vecs[i].key, 1'b0, ct, lat);
      check($sformatf("kat%0d ciphertext", i), ct, vecs[i].ct);
      check($sformatf("kat%0d latency", i), lat, 10);
      roundErrs = 0;
      for (int k = 0; k < 11; k++)
        if (k >= roundLog.size() || roundLog[k] != ((k < 10) ? k + 1 : 0)) roundErrs++;
      check($sformatf("kat%0d round_o sequence errors", i), roundErrs, 0);
      consume(i);
    end

    // Randomized blocks with input noise while busy
    for (int i = 0; i < 8; i++) begin
      pt  = rand128();
      key = rand128();
      runBlock(pt, key, 1'b1, ct, lat);
      check($sformatf("rand%0d ciphertext", i), ct, refEncrypt(pt, key));
      check($sformatf("rand%0d latency", i), lat, 10);
      consume($urandom_range(0, 3));
    end

    // Backpressure: result held, new requests ignored
    runBlock(APPB_PT, APPB_KEY, 1'b0, ct, lat);
    for (int i = 0; i < 20; i++) begin
      v_i = 1'b1;
      plaintext_i = rand128();
      key_i = rand128();
      @(negedge clk_i);
      check("backpressure ciphertext_o", ciphertext_o, APPB_CT);
      check("backpressure ready_o", ready_o, 0);
      check("backpressure v_o", v_o, 1);
    end
    v_i = 1'b0;
    consume(0);
    runBlock(APPC_PT, APPC_KEY, 1'b0, ct, lat);
    check("after backpressure ciphertext", ct, APPC_CT);
    consume(0);

    // Reset at round 5
    plaintext_i = APPB_PT; key_i = APPB_KEY; v_i = 1'b1;
    @(negedge clk_i);
    v_i = 1'b0;
    n = 0;
    while (round_o != 4'd5 && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    check("reached round 5", round_o, 5);
    reset_i = 1'b1;
    #1;
    consumed = 0;
    check("mid-round reset v_o", v_o, 0);
    check("mid-round reset ready_o", ready_o, 1);
    check("mid-round reset round_o", round_o, 0);
    @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
    runBlock(APPB_PT, APPB_KEY, 1'b0, ct, lat);
    check("post-reset ciphertext", ct, APPB_CT);
    check("post-reset latency", lat, 10);

    // Reset while result is presented: v_o drops without an edge
    reset_i = 1'b1;
    #1;
    consumed = 0;
    check("done reset v_o", v_o, 0);
    check("done reset ciphertext_o", ciphertext_o, 0);
    @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);

    for (int i = 0; i < 3; i++) begin
      pt  = rand128();
      key = rand128();
      runBlock(pt, key, 1'b0, ct, lat);
      check($sformatf("tail%0d ciphertext", i), ct, refEncrypt(pt, key));
      consume(0);
    end

`ifdef AES_SEQ_PERF_CNT_EN
    check("blocks_done_o count", blocks_done_o, 128'(consumed));
    force dut.blocksDoneQ = 32'hFFFF_FFFF;
    @(negedge clk_i);
    release dut.blocksDoneQ;
    runBlock(APPC_PT, APPC_KEY, 1'b0, ct, lat);
    consume(0);
    check("blocks_done_o saturated", blocks_done_o, 32'hFFFF_FFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
